// File: rtl/uart_loopback_tester_if.sv
// Byte-stream handshake between the loopback tester and the uart block.
//
// Signals:
//   tx_data     byte offered to the uart transmitter
//   tx_valid    tx_data is valid; a transfer happens when tx_ready is also high
//   tx_ready    uart transmitter can accept a byte this cycle
//   rx_data     byte received by the uart
//   rx_complete one-cycle pulse, rx_data valid
//
// Modports:
//   master  the tester side (drives tx_data/tx_valid, observes the rest)
//   slave   the uart side
interface uart_loopback_tester_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_complete;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_complete
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_complete
    );
endinterface

// File: rtl/uart_loopback_tester.sv
// Loopback tester: streams an LFSR byte sequence into the uart transmit handshake and checks
// every echoed byte against an independently regenerated copy of the same sequence.
//
// Ports:
//   clk, reset   single clock; synchronous active-high reset
//   start        one-cycle pulse, begins a run when idle or done
//   num_bytes    number of bytes in the run, sampled on start
//   uart         master side of uart_loopback_tester_if (tx handshake + rx strobe)
//   busy         run in progress (sending or draining)
//   done         run finished; held until the next start or reset
//   pass         valid with done: no errors and no timeout
//   timeout      run aborted because echoes stopped arriving
//   err_count    mismatches plus unexpected bytes, saturating
//   rx_count     bytes received and checked in the current run
module uart_loopback_tester #(
    parameter logic [7:0]  SEED            = 8'h01,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000,
    parameter int unsigned COUNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_W-1:0]     num_bytes,
    uart_loopback_tester_if.master uart,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [COUNT_W-1:0]     err_count,
    output logic [COUNT_W-1:0]     rx_count
);

    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] num_q, num_d;
    logic [COUNT_W-1:0] sent_q, sent_d;
    logic [COUNT_W-1:0] err_q, err_d;
    logic [COUNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [7:0]         tx_lfsr_q, tx_lfsr_d;
    logic [7:0]         exp_lfsr_q, exp_lfsr_d;
    logic               timeout_q, timeout_d;
    logic               pass_q, pass_d;

    logic active;
    logic counting;
    logic timeout_hit;
    logic tx_valid_int;
    logic xfer;
    logic rx_ev;
    logic rx_chk;
    logic rx_bad;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    always_comb begin
        active   = (state_q == StRun) || (state_q == StDrain);
        counting = active && (out_q != '0);
        // The idle counter would reach TIMEOUT_CYCLES at the end of this cycle; abort now so
        // tx_valid is already low on the aborting cycle.
        timeout_hit = counting && !uart.rx_complete &&
                      (32'(idle_q) == TIMEOUT_CYCLES - 32'd1);

        tx_valid_int = (state_q == StRun) && (sent_q < num_q) &&
                       (32'(out_q) < MAX_OUTSTANDING) && !timeout_hit;
        xfer         = tx_valid_int && uart.tx_ready;

        rx_ev  = active && uart.rx_complete;
        rx_chk = rx_ev && (out_q != '0);
        // A byte with nothing outstanding is unexpected and always counts as an error.
        rx_bad = (rx_chk && (uart.rx_data != exp_lfsr_q)) || (rx_ev && (out_q == '0));
    end

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        sent_d     = sent_q;
        err_d      = err_q;
        rx_cnt_d   = rx_cnt_q;
        out_d      = out_q;
        tx_lfsr_d  = tx_lfsr_q;
        exp_lfsr_d = exp_lfsr_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    num_d      = num_bytes;
                    sent_d     = '0;
                    err_d      = '0;
                    rx_cnt_d   = '0;
                    out_d      = '0;
                    tx_lfsr_d  = SEED;
                    exp_lfsr_d = SEED;
                    timeout_d  = 1'b0;
                    if (num_bytes == '0) begin
                        state_d = StDone;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        pass_d  = 1'b0;
                    end
                end
            end

            StRun, StDrain: begin
                if (xfer) begin
                    tx_lfsr_d = lfsr_step(tx_lfsr_q);
                    sent_d    = sent_q + 1'b1;
                end
                if (rx_chk) begin
                    exp_lfsr_d = lfsr_step(exp_lfsr_q);
                    rx_cnt_d   = rx_cnt_q + 1'b1;
                end
                if (rx_bad && (err_q != '1)) begin
                    err_d = err_q + 1'b1;
                end

                unique case ({xfer, rx_chk})
                    2'b10:   out_d = out_q + 1'b1;
                    2'b01:   out_d = out_q - 1'b1;
                    default: out_d = out_q;
                endcase

                if (timeout_hit) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else if ((state_q == StRun) && xfer && (sent_q + 1'b1 == num_q)) begin
                    state_d = StDrain;
                end else if ((state_q == StDrain) && (out_q == '0)) begin
                    state_d = StDone;
                    pass_d  = (err_d == '0);
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Idle counter restarts on any received byte and on every state change.
    always_comb begin
        idle_d = idle_q;
        if (uart.rx_complete || (state_d != state_q)) begin
            idle_d = '0;
        end else if (counting) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            num_q      <= '0;
            sent_q     <= '0;
            err_q      <= '0;
            rx_cnt_q   <= '0;
            out_q      <= '0;
            idle_q     <= '0;
            tx_lfsr_q  <= SEED;
            exp_lfsr_q <= SEED;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            sent_q     <= sent_d;
            err_q      <= err_d;
            rx_cnt_q   <= rx_cnt_d;
            out_q      <= out_d;
            idle_q     <= idle_d;
            tx_lfsr_q  <= tx_lfsr_d;
            exp_lfsr_q <= exp_lfsr_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        uart.tx_valid = tx_valid_int;
        // Zero while not offering, so the bus is quiet out of reset and between runs.
        uart.tx_data  = tx_valid_int ? tx_lfsr_q : 8'h00;
        busy          = active;
        done          = (state_q == StDone);
        pass          = pass_q;
        timeout       = timeout_q;
        err_count     = err_q;
        rx_count      = rx_cnt_q;
    end

endmodule

// File: tb/tb_uart_loopback_tester.sv
module tb_uart_loopback_tester;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_bytes;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_count;
    logic [15:0] rx_count;

    uart_loopback_tester_if u_if ();

    uart_loopback_tester #(
        .SEED            (8'h01),
        .MAX_OUTSTANDING (16),
        .TIMEOUT_CYCLES  (100),
        .COUNT_W         (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_bytes (num_bytes),
        .uart      (u_if),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .err_count (err_count),
        .rx_count  (rx_count)
    );

    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Hand-computed LFSR sequence from seed 01.
    logic [7:0] exp_seq [20] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E,
                                 8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25,
                                 8'h4B, 8'h97, 8'h2E, 8'h5C};

    // Echo model state
    logic [7:0] tx_log [256];
    logic [7:0] dl_d [2];
    logic       dl_v [2];
    int         xfer_cnt    = 0;
    int         corrupt_at  = -1;
    int         stray_req   = 0;
    int         stray_ack   = 0;
    int         coin_cnt    = 0;
    bit         hold_mode   = 1'b0;
    bit         toggle_mode = 1'b0;
    bit         ready_phase = 1'b0;
    bit         prev_stall  = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    // Echo target: returns each accepted byte as an rx_complete pulse two cycles later.
    initial begin
        u_if.tx_ready    = 1'b1;
        u_if.rx_complete = 1'b0;
        u_if.rx_data     = 8'h00;
        dl_v[0] = 1'b0; dl_v[1] = 1'b0;
        dl_d[0] = 8'h00; dl_d[1] = 8'h00;
        forever begin
            @(negedge clk);
            u_if.rx_complete = dl_v[1];
            u_if.rx_data     = dl_d[1];
            if (stray_req != stray_ack) begin
                u_if.rx_complete = 1'b1;
                u_if.rx_data     = 8'h55;
                stray_ack++;
            end
            dl_v[1] = dl_v[0];
            dl_d[1] = dl_d[0];
            ready_phase   = ~ready_phase;
            u_if.tx_ready = toggle_mode ? ready_phase : 1'b1;
            #1;
            if (toggle_mode && prev_stall && !reset) begin
                check("stall_valid", 32'(u_if.tx_valid), 32'd1);
                check("stall_data", 32'(u_if.tx_data), 32'(prev_data));
            end
            prev_stall = u_if.tx_valid && !u_if.tx_ready;
            prev_data  = u_if.tx_data;
            dl_v[0] = 1'b0;
            dl_d[0] = 8'h00;
            if (u_if.tx_valid && u_if.tx_ready && !reset) begin
                tx_log[xfer_cnt[7:0]] = u_if.tx_data;
                if (u_if.rx_complete) coin_cnt++;
                if (!hold_mode) begin
                    dl_v[0] = 1'b1;
                    dl_d[0] = (xfer_cnt == corrupt_at) ? 8'hFF : u_if.tx_data;
                end
                xfer_cnt++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse start for one cycle; returns 2 time units after the following falling edge.
    task automatic run_start(input int n);
        @(negedge clk);
        num_bytes = 16'(n);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            @(negedge clk);
            #2;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_seq(input int base, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check(tag, 32'(tx_log[8'(base + i)]), 32'(exp_seq[i]));
        end
    endtask

    int base;
    int coin0;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        num_bytes = 16'd0;

        // Reset state
        do_reset();
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_rx", 32'(rx_count), 32'd0);
        check("rst_tx_valid", 32'(u_if.tx_valid), 32'd0);

        // Clean run of 6 bytes
        base = xfer_cnt;
        run_start(6);
        check("t1_busy_n1", 32'(busy), 32'd1);
        check("t1_valid_n1", 32'(u_if.tx_valid), 32'd1);
        check("t1_data_n1", 32'(u_if.tx_data), 32'h01);
        wait_done(200, "t1_done");
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_rx", 32'(rx_count), 32'd6);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_xfers", 32'(xfer_cnt - base), 32'd6);
        check_seq(base, 6, "t1_seq");

        // Third echoed byte corrupted
        do_reset();
        base       = xfer_cnt;
        corrupt_at = base + 2;
        run_start(6);
        wait_done(200, "t2_done");
        check("t2_pass", 32'(pass), 32'd0);
        check("t2_err", 32'(err_count), 32'd1);
        check("t2_rx", 32'(rx_count), 32'd6);
        corrupt_at = -1;

        // Echo never returns: window fills, then timeout
        do_reset();
        hold_mode = 1'b1;
        base      = xfer_cnt;
        run_start(40);
        repeat (30) @(negedge clk);
        #2;
        check("t3_window_xfers", 32'(xfer_cnt - base), 32'd16);
        check("t3_valid_low", 32'(u_if.tx_valid), 32'd0);
        check("t3_still_busy", 32'(busy), 32'd1);
        wait_done(300, "t3_done");
        check("t3_timeout", 32'(timeout), 32'd1);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_final_xfers", 32'(xfer_cnt - base), 32'd16);
        check("t3_rx", 32'(rx_count), 32'd0);
        hold_mode = 1'b0;

        // tx_ready toggling; echoes land on transfer cycles
        do_reset();
        toggle_mode = 1'b1;
        base        = xfer_cnt;
        coin0       = coin_cnt;
        run_start(20);
        wait_done(400, "t4_done");
        check("t4_pass", 32'(pass), 32'd1);
        check("t4_err", 32'(err_count), 32'd0);
        check("t4_rx", 32'(rx_count), 32'd20);
        check("t4_xfers", 32'(xfer_cnt - base), 32'd20);
        check("t4_coincident", 32'(coin_cnt > coin0), 32'd1);
        check_seq(base, 20, "t4_seq");
        @(negedge clk);
        toggle_mode = 1'b0;

        // Zero-length run
        do_reset();
        base = xfer_cnt;
        run_start(0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_pass", 32'(pass), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(u_if.tx_valid), 32'd0);
        check("t5_xfers", 32'(xfer_cnt - base), 32'd0);

        // Reset mid-run, stray byte in idle, then a fresh run
        do_reset();
        base = xfer_cnt;
        run_start(10);
        for (int i = 0; i < 100; i++) begin
            if (xfer_cnt - base >= 5) break;
            @(negedge clk);
            #2;
        end
        check("t6_reached5", 32'(xfer_cnt - base >= 5), 32'd1);
        do_reset();
        stray_req++;
        repeat (4) @(negedge clk);
        #2;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_pass", 32'(pass), 32'd0);
        check("t6_timeout", 32'(timeout), 32'd0);
        check("t6_err", 32'(err_count), 32'd0);
        check("t6_rx", 32'(rx_count), 32'd0);
        check("t6_valid", 32'(u_if.tx_valid), 32'd0);
        base = xfer_cnt;
        run_start(3);
        wait_done(100, "t6_fresh_done");
        check("t6_fresh_pass", 32'(pass), 32'd1);
        check("t6_fresh_rx", 32'(rx_count), 32'd3);
        check("t6_fresh_xfers", 32'(xfer_cnt - base), 32'd3);
        check_seq(base, 3, "t6_fresh_seq");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule
